// File: rtl/corner_list_collector.sv
// Collects corner coordinates from the pixel stream into a FIFO and appends a
// per-frame summary word {drop_cnt, corner_cnt}, presented on a valid/ready stream.
module corner_list_collector #(
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480,
    parameter int COORD_W = 10,
    parameter int DEPTH   = 64,
    parameter int CNT_W   = 12,
    parameter int DROP_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   iscorner,
    input  logic [COORD_W-1:0]     x_coord,
    input  logic [COORD_W-1:0]     y_coord,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [2*COORD_W+1:0]   m_data,
    output logic                   m_last,
    output logic                   overflow
);

    localparam int PW = 2 * COORD_W;
    localparam int W  = PW + 2;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {COLLECT, SUM_PEND} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    corner_cnt_reg, corner_cnt_next;
    logic [DROP_W-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0]    sum_corner_reg, sum_corner_next;
    logic [DROP_W-1:0]   sum_drop_reg, sum_drop_next;
    logic                overflow_reg, overflow_next;

    logic [W-1:0]        mem [DEPTH];
    logic [AW:0]         wr_ptr_reg, wr_ptr_next;
    logic [AW:0]         rd_ptr_reg, rd_ptr_next;
    logic [W-1:0]        m_data_reg;
    logic                m_valid_reg, m_valid_next;

    logic                full, pop, wr_en, bypass;
    logic                corner_req, corner_acc, corner_drop, sum_wr, frame_end;
    logic [PW-1:0]       sum_payload;
    logic [W-1:0]        wr_data;

    // Full/empty from the extra pointer bit; full is judged before any same-cycle pop.
    assign full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop  = m_valid_reg && m_ready;

    assign frame_end  = ce && (x_coord == COORD_W'(COL_NUM - 1)) &&
                        (y_coord == COORD_W'(ROW_NUM - 1));
    assign corner_req = ce && iscorner;
    assign sum_wr     = (state_reg == SUM_PEND) && !full;
    assign corner_acc = corner_req && !full && !sum_wr;
    assign corner_drop = corner_req && !corner_acc;
    assign wr_en      = sum_wr || corner_acc;

    always_comb begin
        sum_payload = '0;
        sum_payload[CNT_W-1:0]     = sum_corner_reg;
        sum_payload[PW-1 -: DROP_W] = sum_drop_reg;
    end

    assign wr_data = sum_wr ? {2'b10, sum_payload} : {2'b01, y_coord, x_coord};

    always_comb begin
        state_next      = state_reg;
        corner_cnt_next = corner_cnt_reg;
        drop_cnt_next   = drop_cnt_reg;
        sum_corner_next = sum_corner_reg;
        sum_drop_next   = sum_drop_reg;
        overflow_next   = overflow_reg;

        if (corner_acc && (corner_cnt_reg != '1))
            corner_cnt_next = corner_cnt_reg + 1'b1;
        if (corner_drop) begin
            overflow_next = 1'b1;
            if (drop_cnt_reg != '1)
                drop_cnt_next = drop_cnt_reg + 1'b1;
        end

        case (state_reg)
            COLLECT: begin
                // The summary includes whatever happened at the final pixel itself.
                if (frame_end) begin
                    sum_corner_next = corner_cnt_next;
                    sum_drop_next   = drop_cnt_next;
                    corner_cnt_next = '0;
                    drop_cnt_next   = '0;
                    state_next      = SUM_PEND;
                end
            end
            SUM_PEND: begin
                if (sum_wr)
                    state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= COLLECT;
            corner_cnt_reg <= '0;
            drop_cnt_reg   <= '0;
            sum_corner_reg <= '0;
            sum_drop_reg   <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            corner_cnt_reg <= corner_cnt_next;
            drop_cnt_reg   <= drop_cnt_next;
            sum_corner_reg <= sum_corner_next;
            sum_drop_reg   <= sum_drop_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign wr_ptr_next  = wr_ptr_reg + {{AW{1'b0}}, wr_en};
    assign rd_ptr_next  = rd_ptr_reg + {{AW{1'b0}}, pop};
    assign m_valid_next = (wr_ptr_next != rd_ptr_next);
    // A write landing on the next head address must be forwarded past the RAM read.
    assign bypass = wr_en && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            m_valid_reg <= m_valid_next;
            if (m_valid_next)
                m_data_reg <= bypass ? wr_data : mem[rd_ptr_next[AW-1:0]];
        end
    end

    assign m_valid  = m_valid_reg;
    assign m_data   = m_data_reg;
    assign m_last   = m_valid_reg && (m_data_reg[W-1:W-2] == 2'b10);
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_corner_list_collector.sv
// Directed bench for corner_list_collector: corner words, per-frame summaries,
// backpressure drops, pending summary priority, stall stability and async reset.
module tb_corner_list_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        iscorner = 1'b0;
    logic [9:0]  x_coord = '0;
    logic [9:0]  y_coord = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [21:0] m_data;
    logic        m_last;
    logic        overflow;

    int n_checks = 0;
    int n_fails  = 0;
    logic [22:0] obs_q[$];

    corner_list_collector dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .iscorner (iscorner),
        .x_coord  (x_coord),
        .y_coord  (y_coord),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Record every accepted word as {m_last, m_data}.
    always @(negedge clk)
        if (rst && m_valid && m_ready)
            obs_q.push_back({m_last, m_data});

    function automatic logic [31:0] corner_word(input int x, input int y);
        logic [9:0] xv, yv;
        xv = 10'(x);
        yv = 10'(y);
        return {9'd0, 1'b0, 2'b01, yv, xv};
    endfunction

    function automatic logic [31:0] sum_word(input int c, input int d);
        logic [11:0] cv;
        logic [7:0]  dv;
        cv = 12'(c);
        dv = 8'(d);
        return {9'd0, 1'b1, 2'b10, dv, cv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] obs;
        obs = (idx < obs_q.size()) ? {9'd0, obs_q[idx]} : 32'hDEADBEEF;
        chk(tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix(input int x, input int y, input logic c);
        ce = 1'b1;
        iscorner = c;
        x_coord = 10'(x);
        y_coord = 10'(y);
        tick();
        ce = 1'b0;
        iscorner = 1'b0;
    endtask

    task automatic do_reset();
        ce = 1'b0;
        iscorner = 1'b0;
        m_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        obs_q.delete();
    endtask

    initial begin
        // Reset holds everything idle even with corners presented.
        rst = 1'b0;
        ce = 1'b1;
        iscorner = 1'b1;
        x_coord = 10'd5;
        y_coord = 10'd3;
        idle(3);
        chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_m_data", {10'd0, m_data}, 32'd0);
        chk("reset_m_last", {31'd0, m_last}, 32'd0);
        ce = 1'b0;
        iscorner = 1'b0;
        rst = 1'b1;
        tick();
        pix(5, 3, 1'b1);
        chk("first_valid", {31'd0, m_valid}, 32'd1);
        chk("first_data", {10'd0, m_data}, corner_word(5, 3) & 32'h3FFFFF);

        // Full frame, downstream always ready; last corner at the final pixel.
        do_reset();
        m_ready = 1'b1;
        pix(1, 1, 1'b1);
        pix(2, 1, 1'b0);
        pix(639, 100, 1'b1);
        pix(639, 479, 1'b1);
        idle(6);
        chk("frame_count", obs_q.size(), 32'd4);
        chk_q("frame_w0", 0, corner_word(1, 1));
        chk_q("frame_w1", 1, corner_word(639, 100));
        chk_q("frame_w2", 2, corner_word(639, 479));
        chk_q("frame_sum", 3, sum_word(3, 0));
        chk("frame_overflow", {31'd0, overflow}, 32'd0);

        // Backpressure: 70 corners into a 64-deep FIFO.
        do_reset();
        for (int i = 0; i < 70; i++) pix(i, 10, 1'b1);
        chk("bp_overflow", {31'd0, overflow}, 32'd1);
        chk("bp_none_out", obs_q.size(), 32'd0);
        m_ready = 1'b1;
        pix(639, 479, 1'b0);
        idle(70);
        chk("bp_count", obs_q.size(), 32'd65);
        chk_q("bp_first", 0, corner_word(0, 10));
        chk_q("bp_last_corner", 63, corner_word(63, 10));
        chk_q("bp_sum", 64, sum_word(64, 6));
        chk("bp_drained", {31'd0, m_valid}, 32'd0);

        // Summary pending on a full FIFO; corners competing with it are dropped.
        do_reset();
        for (int i = 0; i < 64; i++) pix(i, 20, 1'b1);
        pix(639, 479, 1'b0);
        idle(3);
        chk("pend_no_overflow", {31'd0, overflow}, 32'd0);
        m_ready = 1'b1;
        pix(8, 0, 1'b1);
        m_ready = 1'b0;
        pix(9, 0, 1'b1);
        chk("pend_overflow", {31'd0, overflow}, 32'd1);
        m_ready = 1'b1;
        idle(70);
        pix(639, 479, 1'b0);
        idle(4);
        chk("pend_count", obs_q.size(), 32'd66);
        chk_q("pend_first", 0, corner_word(0, 20));
        chk_q("pend_last_corner", 63, corner_word(63, 20));
        chk_q("pend_sum1", 64, sum_word(64, 0));
        chk_q("pend_sum2", 65, sum_word(0, 2));

        // Stall stability: word held under m_ready=0 while ce=0 and iscorner toggles.
        do_reset();
        pix(12, 34, 1'b1);
        iscorner = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", {10'd0, m_data}, corner_word(12, 34) & 32'h3FFFFF);
            chk("stall_last", {31'd0, m_last}, 32'd0);
        end
        iscorner = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("stall_accept_count", obs_q.size(), 32'd1);
        chk_q("stall_accept_word", 0, corner_word(12, 34));
        chk("stall_empty", {31'd0, m_valid}, 32'd0);

        // Asynchronous reset mid-frame discards buffered corners and counts.
        do_reset();
        for (int i = 0; i < 10; i++) pix(i, 40, 1'b1);
        chk("mid_valid_before", {31'd0, m_valid}, 32'd1);
        rst = 1'b0;
        #2;
        chk("mid_async_valid", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        obs_q.delete();
        m_ready = 1'b1;
        pix(3, 3, 1'b1);
        pix(4, 4, 1'b1);
        pix(639, 479, 1'b0);
        idle(5);
        chk("mid_count", obs_q.size(), 32'd3);
        chk_q("mid_w0", 0, corner_word(3, 3));
        chk_q("mid_w1", 1, corner_word(4, 4));
        chk_q("mid_sum", 2, sum_word(2, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
